router_switch_ctrl: RTL and testbench

Switch-control unit for the 5-port credit-based mesh router.
- Takes header requests from the five input buffers and arbitrates them round-robin.
- Computes the XY route from the header flit and allocates a free output port.
- Drives the crossbar selects (mux_in/mux_out), acknowledges the winning buffer, and releases the output when that buffer's sender flag drops.

---
 rtl/router_switch_ctrl_if.sv | 22 ++
 rtl/router_switch_ctrl.sv | 132 +++++++++++++
 tb/tb_router_switch_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/router_switch_ctrl_if.sv
// Header-request / crossbar-select bundle between the input buffers and the switch controller.
interface router_switch_ctrl_if #(
    parameter int FLIT_W = 16
);
    logic [4:0]          h;
    logic [5*FLIT_W-1:0] data;
    logic [4:0]          sender;
    logic [4:0]          ack_h;
    logic [4:0]          free;
    logic [14:0]         mux_in;
    logic [14:0]         mux_out;

    modport master (
        output h, data, sender,
        input  ack_h, free, mux_in, mux_out
    );

    modport slave (
        input  h, data, sender,
        output ack_h, free, mux_in, mux_out
    );
endinterface

// File: rtl/router_switch_ctrl.sv
// Switch control for a 5-port XY mesh router: round-robin header arbitration,
// XY route computation, output allocation and sender-driven release.
//   state | meaning
//   IDLE  | pick next requester round-robin after last_grant
//   ROUTE | compute XY direction from the selected header
//   ALLOC | claim the output if free, else give up this pass
//   ACK   | one-cycle header acknowledge, back to IDLE
module router_switch_ctrl #(
    parameter logic [7:0] ADDRESS = 8'h11,
    parameter int         FLIT_W  = 16
) (
    input logic                 clock,
    input logic                 reset,
    router_switch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUTE, ALLOC, ACK} state_t;

    localparam logic [2:0] P_EAST  = 3'd0;
    localparam logic [2:0] P_WEST  = 3'd1;
    localparam logic [2:0] P_NORTH = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_LOCAL = 3'd4;
    localparam logic [3:0] ADDR_X  = ADDRESS[7:4];
    localparam logic [3:0] ADDR_Y  = ADDRESS[3:0];

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  dir_q, dir_d;
    logic [2:0]  last_grant_q, last_grant_d;
    logic [4:0]  free_q, free_d;
    logic [4:0]  ack_q, ack_d;
    logic [4:0]  sender_q, sender_d;
    logic [14:0] mux_in_q, mux_in_d;
    logic [14:0] mux_out_q, mux_out_d;
    logic [7:0]  head_addr [5];
    logic [3:0]  tx, ty;

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            head_addr[i] = bus.data[FLIT_W*i +: 8];
        end
    end

    assign tx = head_addr[sel_q][7:4];
    assign ty = head_addr[sel_q][3:0];

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        dir_d        = dir_q;
        last_grant_d = last_grant_q;
        free_d       = free_q;
        ack_d        = '0;
        mux_in_d     = mux_in_q;
        mux_out_d    = mux_out_q;
        sender_d     = bus.sender;

        case (state_q)
            IDLE: begin
                if (|bus.h) begin
                    // Descending scan so the closest port after last_grant wins.
                    for (int k = 5; k >= 1; k--) begin
                        if (bus.h[(int'(last_grant_q) + k) % 5]) begin
                            sel_d = 3'((int'(last_grant_q) + k) % 5);
                        end
                    end
                    state_d = ROUTE;
                end
            end
            ROUTE: begin
                if (tx == ADDR_X && ty == ADDR_Y) dir_d = P_LOCAL;
                else if (tx > ADDR_X)             dir_d = P_EAST;
                else if (tx < ADDR_X)             dir_d = P_WEST;
                else if (ty > ADDR_Y)             dir_d = P_NORTH;
                else                              dir_d = P_SOUTH;
                state_d = ALLOC;
            end
            ALLOC: begin
                last_grant_d = sel_q;
                if (free_q[dir_q]) begin
                    free_d[dir_q]           = 1'b0;
                    mux_in_d[3*sel_q +: 3]  = dir_q;
                    mux_out_d[3*dir_q +: 3] = sel_q;
                    ack_d[sel_q]            = 1'b1;
                    state_d                 = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Release runs after allocation so a falling sender always frees its output.
        for (int i = 0; i < 5; i++) begin
            if (sender_q[i] && !bus.sender[i]) begin
                free_d[mux_in_q[3*i +: 3]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            dir_q        <= '0;
            last_grant_q <= P_LOCAL;
            free_q       <= '1;
            ack_q        <= '0;
            sender_q     <= '0;
            mux_in_q     <= '0;
            mux_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            dir_q        <= dir_d;
            last_grant_q <= last_grant_d;
            free_q       <= free_d;
            ack_q        <= ack_d;
            sender_q     <= sender_d;
            mux_in_q     <= mux_in_d;
            mux_out_q    <= mux_out_d;
        end
    end

    assign bus.ack_h   = ack_q;
    assign bus.free    = free_q;
    assign bus.mux_in  = mux_in_q;
    assign bus.mux_out = mux_out_q;
endmodule

// File: tb/tb_router_switch_ctrl.sv
// Bench for router_switch_ctrl: directed scenarios plus randomized buffer traffic
// checked every cycle against a behavioural model of the arbitration/route rules.
module tb_router_switch_ctrl;
    logic clock;
    logic reset;

    router_switch_ctrl_if #(.FLIT_W(16)) tif ();

    router_switch_ctrl #(.ADDRESS(8'h11), .FLIT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (tif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 pick, 1 route, 2 allocate, 3 acknowledge.
    int       m_phase, m_sel, m_dir, m_lg;
    int       m_mi [5];
    int       m_mo [5];
    int       old_mi [5];
    bit [4:0] m_free, m_ack, m_sq, nfree;
    bit       m_valid = 1'b0;

    function automatic int route_dir(input logic [7:0] a);
        int tx, ty;
        tx = int'(a[7:4]);
        ty = int'(a[3:0]);
        if (tx == 1 && ty == 1) return 4;
        if (tx > 1) return 0;
        if (tx < 1) return 1;
        if (ty > 1) return 2;
        return 3;
    endfunction

    always @(posedge clock) begin
        m_valid <= 1'b1;
        if (!reset) begin
            m_phase = 0; m_lg = 4; m_sq = '0; m_free = '1; m_ack = '0;
            m_sel = 0; m_dir = 0;
            for (int i = 0; i < 5; i++) begin m_mi[i] = 0; m_mo[i] = 0; end
        end else begin
            nfree = m_free;
            m_ack = '0;
            for (int i = 0; i < 5; i++) old_mi[i] = m_mi[i];
            case (m_phase)
                0: if (tif.h != 0) begin
                       for (int k = 1; k <= 5; k++) begin
                           if (tif.h[(m_lg + k) % 5]) begin m_sel = (m_lg + k) % 5; break; end
                       end
                       m_phase = 1;
                   end
                1: begin m_dir = route_dir(tif.data[16*m_sel +: 8]); m_phase = 2; end
                2: begin
                       m_lg = m_sel;
                       if (m_free[m_dir]) begin
                           nfree[m_dir] = 1'b0; m_mi[m_sel] = m_dir; m_mo[m_dir] = m_sel;
                           m_ack[m_sel] = 1'b1; m_phase = 3;
                       end else m_phase = 0;
                   end
                default: m_phase = 0;
            endcase
            for (int i = 0; i < 5; i++)
                if (m_sq[i] && !tif.sender[i]) nfree[old_mi[i]] = 1'b1;
            m_free = nfree;
            m_sq = tif.sender;
        end
    end

    function automatic logic [14:0] pack(input int v [5]);
        logic [14:0] r = '0;
        for (int i = 0; i < 5; i++) r[3*i +: 3] = 3'(v[i]);
        return r;
    endfunction

    always @(negedge clock) begin
        if (m_valid) begin
            chk("model_ack_h",   32'(tif.ack_h),   32'(m_ack));
            chk("model_free",    32'(tif.free),    32'(m_free));
            chk("model_mux_in",  32'(tif.mux_in),  32'(pack(m_mi)));
            chk("model_mux_out", 32'(tif.mux_out), 32'(pack(m_mo)));
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; tif.h = '0; tif.sender = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic set_hdr(input int i, input logic [15:0] v);
        tif.data[16*i +: 16] = v;
    endtask

    task automatic wait_ack(input string name, input int i, input int budget);
        int n = 0;
        while (!tif.ack_h[i] && n < budget) begin @(negedge clock); n++; end
        chk(name, 32'(tif.ack_h[i]), 32'd1);
    endtask

    task automatic do_local(input logic [15:0] hdr, input int exp_dir, input string name);
        @(negedge clock);
        set_hdr(4, hdr); tif.h = 5'b10000;
        repeat (3) @(negedge clock);
        chk({name, "_ack"}, 32'(tif.ack_h), 32'h10);
        chk({name, "_mux_in4"}, 32'(tif.mux_in[14:12]), 32'(exp_dir));
        chk({name, "_free"}, 32'(tif.free), 32'(5'b11111 & ~(5'b1 << exp_dir)));
        tif.h = '0; tif.sender[4] = 1'b1;
        @(negedge clock);
        chk({name, "_ack_drop"}, 32'(tif.ack_h), 32'h0);
        tif.sender[4] = 1'b0;
        @(negedge clock);
        chk({name, "_release"}, 32'(tif.free), 32'h1f);
    endtask

    int bst [5];
    int bcnt [5];
    int order [$];
    int stamp [$];

    initial begin
        reset = 1'b0; tif.h = '0; tif.sender = '0; tif.data = '0;
        do_reset();
        chk("reset_free", 32'(tif.free), 32'h1f);
        chk("reset_ack", 32'(tif.ack_h), 32'h0);

        // Local delivery, then the four compass directions.
        do_local(16'h0011, 4, "local");
        do_local(16'h0021, 0, "east");
        do_local(16'h0001, 1, "west");
        do_local(16'h0012, 2, "north");
        do_local(16'h0010, 3, "south");

        // Contention for EAST between ports 0 and 1.
        do_reset();
        set_hdr(0, 16'h0021); set_hdr(1, 16'h0021); tif.h = 5'b00011;
        repeat (3) @(negedge clock);
        chk("cont_first_ack", 32'(tif.ack_h), 32'h01);
        chk("cont_mux_out0", 32'(tif.mux_out[2:0]), 32'd0);
        tif.h[0] = 1'b0; tif.sender[0] = 1'b1;
        begin
            int late = 0;
            repeat (12) begin @(negedge clock); if (tif.ack_h[1]) late++; end
            chk("cont_no_ack_busy", 32'(late), 32'd0);
        end
        tif.sender[0] = 1'b0;
        wait_ack("cont_second_ack", 1, 20);
        chk("cont_mux_out0_b", 32'(tif.mux_out[2:0]), 32'd1);
        tif.h[1] = 1'b0; tif.sender[1] = 1'b1;
        @(negedge clock); tif.sender[1] = 1'b0;

        // Fairness: all five request distinct outputs at once.
        do_reset();
        set_hdr(0, 16'h0021); set_hdr(1, 16'h0001); set_hdr(2, 16'h0012);
        set_hdr(3, 16'h0010); set_hdr(4, 16'h0011);
        tif.h = 5'b11111;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            for (int i = 0; i < 5; i++) begin
                if (tif.ack_h[i]) begin
                    order.push_back(i); stamp.push_back(c);
                    tif.h[i] = 1'b0; tif.sender[i] = 1'b1;
                end
            end
        end
        chk("fair_count", 32'(order.size()), 32'd5);
        for (int k = 0; k < order.size(); k++) begin
            chk("fair_order", 32'(order[k]), 32'(k));
            if (k > 0) chk("fair_gap", 32'(stamp[k] - stamp[k-1]), 32'd4);
        end
        chk("fair_free_all_busy", 32'(tif.free), 32'h0);

        // Reset while a new request is in ROUTE with grants outstanding.
        set_hdr(0, 16'h0021); tif.h = 5'b00001;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midreset_free", 32'(tif.free), 32'h1f);
        chk("midreset_ack", 32'(tif.ack_h), 32'h0);
        reset = 1'b1; tif.sender = '0; tif.h = 5'b10001;
        repeat (3) @(negedge clock);
        chk("midreset_search_from0", 32'(tif.ack_h), 32'h01);
        tif.h[0] = 1'b0; tif.sender[0] = 1'b1;
        wait_ack("midreset_port4", 4, 20);
        tif.h[4] = 1'b0; tif.sender[4] = 1'b1;
        @(negedge clock); tif.sender = '0;

        // Randomized buffer traffic: request, hold until ack, send, drop sender.
        do_reset();
        for (int i = 0; i < 5; i++) begin bst[i] = 0; bcnt[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (c == 1500) begin
                reset = 1'b0; tif.h = '0; tif.sender = '0;
                for (int i = 0; i < 5; i++) bst[i] = 0;
                @(negedge clock);
                reset = 1'b1;
            end
            for (int i = 0; i < 5; i++) begin
                case (bst[i])
                    0: if ($urandom_range(0, 3) == 0) begin
                           set_hdr(i, {8'($urandom), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))});
                           tif.h[i] = 1'b1; bst[i] = 1;
                       end
                    1: if (tif.ack_h[i]) begin
                           tif.h[i] = 1'b0; tif.sender[i] = 1'b1;
                           bcnt[i] = $urandom_range(1, 10); bst[i] = 2;
                       end
                    2: if (bcnt[i] == 0) begin tif.sender[i] = 1'b0; bst[i] = 3; end
                       else bcnt[i]--;
                    default: bst[i] = 0;
                endcase
            end
        end
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
